// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition-code register, cmov/jXX condition evaluation
// and the M pipeline register with stall/bubble control.
module execute_stage #(
    parameter int W = 64,
    parameter int STACK_STEP = 8,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   E_stat,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [W-1:0] E_valC,
    input  logic [W-1:0] E_valA,
    input  logic [W-1:0] E_valB,
    input  logic [3:0]   E_dstE,
    input  logic [3:0]   E_dstM,
    input  logic         set_cc_en,
    input  logic         M_stall,
    input  logic         M_bubble,
    output logic [W-1:0] e_valE,
    output logic [3:0]   e_dstE,
    output logic         e_cnd,
    output logic         ZF,
    output logic         SF,
    output logic         OF,
    output logic [2:0]   M_stat,
    output logic [3:0]   M_icode,
    output logic         M_cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM
);

    localparam logic [W-1:0] STEP = W'(STACK_STEP);

    logic         zf_q, zf_d, sf_q, sf_d, of_q, of_d;
    logic [2:0]   stat_q, stat_d;
    logic [3:0]   icode_q, icode_d;
    logic         cnd_q, cnd_d;
    logic [W-1:0] vale_q, vale_d;
    logic [W-1:0] vala_q, vala_d;
    logic [3:0]   dste_q, dste_d;
    logic [3:0]   dstm_q, dstm_d;
    logic [W-1:0] alu;
    logic         cond;
    logic         sa, sb, sr;

    always_comb begin
        alu = '0;
        case (E_icode)
            4'h2: alu = E_valA;
            4'h3: alu = E_valC;
            4'h4, 4'h5: alu = E_valB + E_valC;
            4'h6: begin
                case (E_ifun)
                    4'h0: alu = E_valB + E_valA;
                    4'h1: alu = E_valB - E_valA;
                    4'h2: alu = E_valB & E_valA;
                    4'h3: alu = E_valB ^ E_valA;
                    default: alu = '0;
                endcase
            end
            4'h8, 4'hA: alu = E_valB - STEP;
            4'h9, 4'hB: alu = E_valB + STEP;
            default: alu = '0;
        endcase
    end

    // Condition uses the CC currently held, never the value being written this cycle.
    always_comb begin
        cond = 1'b0;
        case (E_ifun)
            4'h0: cond = 1'b1;
            4'h1: cond = (sf_q ^ of_q) | zf_q;
            4'h2: cond = sf_q ^ of_q;
            4'h3: cond = zf_q;
            4'h4: cond = !zf_q;
            4'h5: cond = !(sf_q ^ of_q);
            4'h6: cond = !(sf_q ^ of_q) && !zf_q;
            default: cond = 1'b0;
        endcase
        if (E_icode != 4'h2 && E_icode != 4'h7) begin
            cond = 1'b0;
        end
    end

    assign e_valE = alu;
    assign e_cnd  = cond;
    assign e_dstE = (E_icode == 4'h2 && !cond) ? RNONE : E_dstE;

    assign sa = E_valA[W-1];
    assign sb = E_valB[W-1];
    assign sr = alu[W-1];

    always_comb begin
        zf_d = zf_q;
        sf_d = sf_q;
        of_d = of_q;
        if (E_icode == 4'h6 && set_cc_en) begin
            zf_d = (alu == '0);
            sf_d = sr;
            case (E_ifun)
                4'h0: of_d = (sa == sb) && (sr != sa);
                4'h1: of_d = (sa != sb) && (sr != sb);
                default: of_d = 1'b0;
            endcase
        end
    end

    // Bubble wins over stall; reset shares the bubble's nop encoding.
    always_comb begin
        stat_d  = stat_q;
        icode_d = icode_q;
        cnd_d   = cnd_q;
        vale_d  = vale_q;
        vala_d  = vala_q;
        dste_d  = dste_q;
        dstm_d  = dstm_q;
        if (M_bubble) begin
            stat_d  = 3'd1;
            icode_d = 4'h1;
            cnd_d   = 1'b0;
            vale_d  = '0;
            vala_d  = '0;
            dste_d  = RNONE;
            dstm_d  = RNONE;
        end else if (!M_stall) begin
            stat_d  = E_stat;
            icode_d = E_icode;
            cnd_d   = cond;
            vale_d  = alu;
            vala_d  = E_valA;
            dste_d  = e_dstE;
            dstm_d  = E_dstM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            zf_q    <= 1'b1;
            sf_q    <= 1'b0;
            of_q    <= 1'b0;
            stat_q  <= 3'd1;
            icode_q <= 4'h1;
            cnd_q   <= 1'b0;
            vale_q  <= '0;
            vala_q  <= '0;
            dste_q  <= RNONE;
            dstm_q  <= RNONE;
        end else begin
            zf_q    <= zf_d;
            sf_q    <= sf_d;
            of_q    <= of_d;
            stat_q  <= stat_d;
            icode_q <= icode_d;
            cnd_q   <= cnd_d;
            vale_q  <= vale_d;
            vala_q  <= vala_d;
            dste_q  <= dste_d;
            dstm_q  <= dstm_d;
        end
    end

    assign ZF      = zf_q;
    assign SF      = sf_q;
    assign OF      = of_q;
    assign M_stat  = stat_q;
    assign M_icode = icode_q;
    assign M_cnd   = cnd_q;
    assign M_valE  = vale_q;
    assign M_valA  = vala_q;
    assign M_dstE  = dste_q;
    assign M_dstM  = dstm_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: ALU, CC, conditions and M register control.
module tb_execute_stage;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   E_stat;
    logic [3:0]   E_icode, E_ifun, E_dstE, E_dstM;
    logic [W-1:0] E_valC, E_valA, E_valB;
    logic         set_cc_en, M_stall, M_bubble;
    logic [W-1:0] e_valE, M_valE, M_valA;
    logic [3:0]   e_dstE, M_icode, M_dstE, M_dstM;
    logic         e_cnd, ZF, SF, OF, M_cnd;
    logic [2:0]   M_stat;

    int n_checks = 0;
    int n_fail = 0;

    execute_stage dut (
        .clk(clk), .reset(reset),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .set_cc_en(set_cc_en), .M_stall(M_stall), .M_bubble(M_bubble),
        .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd),
        .ZF(ZF), .SF(SF), .OF(OF),
        .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    always #5 clk = ~clk;

    task automatic set_e(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] vc, input logic [3:0] de, input logic [3:0] dm);
        E_stat = 3'd1; E_icode = icode; E_ifun = ifun;
        E_valA = va; E_valB = vb; E_valC = vc; E_dstE = de; E_dstM = dm;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; M_stall = 1'b0; M_bubble = 1'b0; set_cc_en = 1'b1;
        set_e(4'h1, 4'h0, '0, '0, '0, 4'hF, 4'hF);
        tick();
        reset = 1'b0;
        n_checks++; if ({ZF, SF, OF} !== 3'b100) begin n_fail++; $display("FAIL reset_cc got %b want 100", {ZF, SF, OF}); end
        n_checks++; if (M_icode !== 4'h1) begin n_fail++; $display("FAIL reset_icode got %h want 1", M_icode); end
        n_checks++; if (M_dstE !== 4'hF) begin n_fail++; $display("FAIL reset_dstE got %h want f", M_dstE); end
        n_checks++; if (M_valE !== 64'h0) begin n_fail++; $display("FAIL reset_valE got %h want 0", M_valE); end
        n_checks++; if (M_stat !== 3'd1) begin n_fail++; $display("FAIL reset_stat got %0d want 1", M_stat); end
    endtask

    task automatic test_add_overflow();
        set_e(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, '0, 4'h2, 4'hF);
        n_checks++; if (e_valE !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL add_evalE got %h want 8000000000000000", e_valE); end
        tick();
        n_checks++; if ({ZF, SF, OF} !== 3'b011) begin n_fail++; $display("FAIL add_cc got %b want 011", {ZF, SF, OF}); end
        n_checks++; if (M_valE !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL add_MvalE got %h", M_valE); end
        n_checks++; if (M_icode !== 4'h6 || M_dstE !== 4'h2) begin n_fail++; $display("FAIL add_Mfields got %h/%h want 6/2", M_icode, M_dstE); end
    endtask

    task automatic test_sub_and_jumps();
        set_e(4'h6, 4'h1, 64'h1, 64'h8000_0000_0000_0000, '0, 4'h2, 4'hF);
        n_checks++; if (e_valE !== 64'h7FFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL sub_evalE got %h", e_valE); end
        tick();
        n_checks++; if ({ZF, SF, OF} !== 3'b001) begin n_fail++; $display("FAIL sub_cc got %b want 001", {ZF, SF, OF}); end
        set_e(4'h7, 4'h2, '0, '0, '0, 4'hF, 4'hF);
        n_checks++; if (e_cnd !== 1'b1) begin n_fail++; $display("FAIL jl got %b want 1", e_cnd); end
        set_e(4'h7, 4'h5, '0, '0, '0, 4'hF, 4'hF);
        n_checks++; if (e_cnd !== 1'b0) begin n_fail++; $display("FAIL jge got %b want 0", e_cnd); end
        set_e(4'h6, 4'h2, 64'hF0F0, 64'h0FF0, '0, 4'h2, 4'hF);
        n_checks++; if (e_valE !== 64'h00F0) begin n_fail++; $display("FAIL and_evalE got %h want f0", e_valE); end
        set_e(4'h3, 4'h0, '0, '0, 64'h55, 4'h4, 4'hF);
        n_checks++; if (e_cnd !== 1'b0) begin n_fail++; $display("FAIL irmovq_cnd got %b want 0", e_cnd); end
    endtask

    task automatic test_cmov();
        set_e(4'h6, 4'h1, 64'h5, 64'h5, '0, 4'h2, 4'hF);
        tick();
        n_checks++; if ({ZF, SF, OF} !== 3'b100) begin n_fail++; $display("FAIL sub_eq_cc got %b want 100", {ZF, SF, OF}); end
        set_e(4'h2, 4'h4, 64'h77, '0, '0, 4'h3, 4'hF);
        n_checks++; if (e_cnd !== 1'b0 || e_dstE !== 4'hF) begin n_fail++; $display("FAIL cmovne got cnd=%b dst=%h want 0/f", e_cnd, e_dstE); end
        n_checks++; if (e_valE !== 64'h77) begin n_fail++; $display("FAIL cmov_evalE got %h want 77", e_valE); end
        tick();
        n_checks++; if (M_dstE !== 4'hF || M_cnd !== 1'b0) begin n_fail++; $display("FAIL cmovne_M got dst=%h cnd=%b want f/0", M_dstE, M_cnd); end
        set_e(4'h2, 4'h3, 64'h77, '0, '0, 4'h3, 4'hF);
        n_checks++; if (e_cnd !== 1'b1 || e_dstE !== 4'h3) begin n_fail++; $display("FAIL cmove got cnd=%b dst=%h want 1/3", e_cnd, e_dstE); end
        tick();
        n_checks++; if (M_dstE !== 4'h3 || M_cnd !== 1'b1) begin n_fail++; $display("FAIL cmove_M got dst=%h cnd=%b want 3/1", M_dstE, M_cnd); end
    endtask

    task automatic test_stack();
        set_e(4'hA, 4'h0, 64'h9, 64'h100, '0, 4'h4, 4'hF);
        n_checks++; if (e_valE !== 64'hF8) begin n_fail++; $display("FAIL pushq got %h want f8", e_valE); end
        tick();
        set_e(4'hB, 4'h0, 64'h0, 64'hF8, '0, 4'h4, 4'h1);
        n_checks++; if (e_valE !== 64'h100) begin n_fail++; $display("FAIL popq got %h want 100", e_valE); end
        tick();
        n_checks++; if ({ZF, SF, OF} !== 3'b100) begin n_fail++; $display("FAIL stack_cc got %b want 100", {ZF, SF, OF}); end
        n_checks++; if (M_dstM !== 4'h1 || M_valA !== 64'h0) begin n_fail++; $display("FAIL popq_M got dstM=%h valA=%h", M_dstM, M_valA); end
        set_e(4'h5, 4'h0, '0, 64'h20, 64'h18, 4'hF, 4'h2);
        n_checks++; if (e_valE !== 64'h38) begin n_fail++; $display("FAIL mrmovq got %h want 38", e_valE); end
    endtask

    task automatic test_cc_gating();
        set_e(4'h6, 4'h0, 64'h1, 64'h2, '0, 4'h2, 4'hF);
        tick();
        n_checks++; if ({ZF, SF, OF} !== 3'b000) begin n_fail++; $display("FAIL add3_cc got %b want 000", {ZF, SF, OF}); end
        set_e(4'h7, 4'h6, '0, '0, '0, 4'hF, 4'hF);
        n_checks++; if (e_cnd !== 1'b1) begin n_fail++; $display("FAIL jg got %b want 1", e_cnd); end
        set_cc_en = 1'b0;
        set_e(4'h6, 4'h3, 64'hAA, 64'hAA, '0, 4'h2, 4'hF);
        n_checks++; if (e_valE !== 64'h0) begin n_fail++; $display("FAIL xor_evalE got %h want 0", e_valE); end
        tick();
        n_checks++; if ({ZF, SF, OF} !== 3'b000) begin n_fail++; $display("FAIL gated_cc got %b want 000", {ZF, SF, OF}); end
        set_cc_en = 1'b1;
    endtask

    task automatic test_pipeline_ctrl();
        set_e(4'h3, 4'h0, '0, '0, 64'h1234, 4'h2, 4'hF);
        tick();
        M_stall = 1'b1;
        set_e(4'h6, 4'h0, 64'h10, 64'h20, '0, 4'h5, 4'h6);
        tick();
        set_e(4'h4, 4'h0, 64'h1, 64'h40, 64'h8, 4'h7, 4'h8);
        tick();
        n_checks++; if (M_valE !== 64'h1234 || M_icode !== 4'h3 || M_dstE !== 4'h2) begin n_fail++; $display("FAIL stall got valE=%h icode=%h dstE=%h want 1234/3/2", M_valE, M_icode, M_dstE); end
        n_checks++; if ({ZF, SF, OF} !== 3'b000) begin n_fail++; $display("FAIL stall_cc got %b want 000", {ZF, SF, OF}); end
        M_bubble = 1'b1;
        tick();
        n_checks++; if (M_icode !== 4'h1 || M_dstE !== 4'hF || M_dstM !== 4'hF || M_valE !== 64'h0) begin n_fail++; $display("FAIL bubble got icode=%h dstE=%h dstM=%h valE=%h", M_icode, M_dstE, M_dstM, M_valE); end
        M_stall = 1'b0; M_bubble = 1'b0;
        set_e(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, '0, 4'h2, 4'hF);
        tick();
        n_checks++; if ({ZF, SF, OF} !== 3'b011) begin n_fail++; $display("FAIL pre_reset_cc got %b want 011", {ZF, SF, OF}); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if ({ZF, SF, OF} !== 3'b100) begin n_fail++; $display("FAIL midreset_cc got %b want 100", {ZF, SF, OF}); end
        n_checks++; if (M_icode !== 4'h1 || M_valE !== 64'h0 || M_dstE !== 4'hF) begin n_fail++; $display("FAIL midreset_M got icode=%h valE=%h dstE=%h", M_icode, M_valE, M_dstE); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_and_jumps();
        test_cmov();
        test_stack();
        test_cc_gating();
        test_pipeline_ctrl();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
